clic_nest_ctrl: RTL and testbench

Sequences interrupt entry, exit and tail-chaining between the n_clic priority resolver and the core fetch stage. It accepts the resolved highest-priority pending interrupt and redirects the PC at an instruction boundary. It keeps a return stack of {return PC, previous threshold} and drives the nesting level that selects the register-file bank. The CLIC itself stays purely combinational; this block owns all nesting state.

---
 rtl/clic_nest_ctrl.sv | 123 ++++++++++++
 tb/tb_clic_nest_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_nest_ctrl.sv
// ============================================================================
// Module   : clic_nest_ctrl
// Purpose  : Interrupt entry / exit / tail-chain sequencer with a nesting
//            return stack of {return PC, previous threshold}.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clic_nest_ctrl #(
  parameter int PrioWidth  = 3,
  parameter int VecWidth   = 5,
  parameter int StackDepth = 4,
  parameter int LvlWidth   = $clog2(StackDepth + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 int_req,
  input  logic [PrioWidth-1:0] int_prio,
  input  logic [VecWidth-1:0]  int_vec,
  input  logic [29:0]          int_addr,
  input  logic [31:0]          pc_next,
  input  logic                 boundary,
  input  logic                 ret_req,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 int_ack,
  output logic [VecWidth-1:0]  ack_vec,
  output logic [LvlWidth-1:0]  level,
  output logic [PrioWidth-1:0] thresh,
  output logic                 ovf_err,
  output logic                 unf_err
);

  localparam int IdxWidth = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam logic [LvlWidth-1:0] LvlMax = LvlWidth'(StackDepth);
  localparam logic [LvlWidth-1:0] LvlOne = LvlWidth'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_EXIT  = 2'd2
  } state_t;

  state_t state;

  // Frame storage: word-aligned return PC plus the threshold to restore.
  logic [29:0]          stk_pc [StackDepth];
  logic [PrioWidth-1:0] stk_th [StackDepth];

  logic [LvlWidth-1:0]  top_lvl;
  logic [IdxWidth-1:0]  top_idx;
  logic [IdxWidth-1:0]  push_idx;
  logic [PrioWidth-1:0] saved_thresh;
  logic [29:0]          saved_pc;
  logic                 take_ok;
  logic                 chain_ok;
  logic                 unused_pc;

  assign top_lvl      = level - LvlOne;
  assign top_idx      = top_lvl[IdxWidth-1:0];
  assign push_idx     = level[IdxWidth-1:0];
  assign saved_thresh = stk_th[top_idx];
  assign saved_pc     = stk_pc[top_idx];
  assign take_ok      = (state == ST_IDLE) && boundary && int_req && (int_prio > thresh);
  assign chain_ok     = int_req && (int_prio > saved_thresh);
  assign unused_pc    = &{1'b0, pc_next[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      level       <= '0;
      thresh      <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      int_ack     <= 1'b0;
      ack_vec     <= '0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
    end else begin
      redirect <= 1'b0;
      int_ack  <= 1'b0;
      state    <= ST_IDLE;
      if (state == ST_IDLE) begin
        if (ret_req) begin
          if (level == '0) begin
            unf_err <= 1'b1;
          end else if (chain_ok) begin
            // Tail-chain: reuse the top frame, only the threshold moves.
            state       <= ST_ENTRY;
            thresh      <= int_prio;
            redirect    <= 1'b1;
            redirect_pc <= {int_addr, 2'b00};
            int_ack     <= 1'b1;
            ack_vec     <= int_vec;
          end else begin
            state       <= ST_EXIT;
            thresh      <= saved_thresh;
            level       <= top_lvl;
            redirect    <= 1'b1;
            redirect_pc <= {saved_pc, 2'b00};
          end
        end else if (take_ok) begin
          if (level == LvlMax) begin
            ovf_err <= 1'b1;
          end else begin
            stk_pc[push_idx] <= pc_next[31:2];
            stk_th[push_idx] <= thresh;
            state            <= ST_ENTRY;
            level            <= level + LvlOne;
            thresh           <= int_prio;
            redirect         <= 1'b1;
            redirect_pc      <= {int_addr, 2'b00};
            int_ack          <= 1'b1;
            ack_vec          <= int_vec;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clic_nest_ctrl.sv
// ============================================================================
// Module   : tb_clic_nest_ctrl
// Purpose  : Directed self-checking bench for clic_nest_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clic_nest_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic [2:0]  int_prio;
  logic [4:0]  int_vec;
  logic [29:0] int_addr;
  logic [31:0] pc_next;
  logic        boundary;
  logic        ret_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        int_ack;
  logic [4:0]  ack_vec;
  logic [2:0]  level;
  logic [2:0]  thresh;
  logic        ovf_err;
  logic        unf_err;

  int total = 0;
  int bad   = 0;

  clic_nest_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .int_req    (int_req),
    .int_prio   (int_prio),
    .int_vec    (int_vec),
    .int_addr   (int_addr),
    .pc_next    (pc_next),
    .boundary   (boundary),
    .ret_req    (ret_req),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .int_ack    (int_ack),
    .ack_vec    (ack_vec),
    .level      (level),
    .thresh     (thresh),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_int(input logic req, input logic [2:0] prio, input logic [4:0] vec,
                         input logic [29:0] addr, input logic [31:0] pc);
    int_req  = req;
    int_prio = prio;
    int_vec  = vec;
    int_addr = addr;
    pc_next  = pc;
  endtask

  initial begin
    reset = 1'b0; boundary = 1'b1; ret_req = 1'b0;
    set_int(1'b0, 3'd0, 5'd0, 30'd0, 32'd0);
    tick(); tick();
    reset = 1'b1;
    chk("rst_redirect", {31'd0, redirect}, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_thresh", {29'd0, thresh}, 0);
    chk("rst_errs", {30'd0, ovf_err, unf_err}, 0);

    // boundary low blocks a take
    boundary = 1'b0;
    set_int(1'b1, 3'd3, 5'd1, 30'd35, 32'd28);
    tick();
    chk("nobnd_redirect", {31'd0, redirect}, 0);
    chk("nobnd_level", {29'd0, level}, 0);
    boundary = 1'b1;

    // Vector 1
    tick();
    chk("v1_redirect", {31'd0, redirect}, 1);
    chk("v1_pc", redirect_pc, 140);
    chk("v1_ack", {31'd0, int_ack}, 1);
    chk("v1_vec", {27'd0, ack_vec}, 1);
    chk("v1_level", {29'd0, level}, 1);
    chk("v1_thresh", {29'd0, thresh}, 3);
    int_req = 1'b0;
    tick();
    chk("v1_redirect_drop", {31'd0, redirect}, 0);
    chk("v1_ack_drop", {31'd0, int_ack}, 0);

    // Nested take
    set_int(1'b1, 3'd5, 5'd2, 30'd50, 32'd144);
    tick();
    chk("nest_pc", redirect_pc, 200);
    chk("nest_level", {29'd0, level}, 2);
    chk("nest_thresh", {29'd0, thresh}, 5);
    int_req = 1'b0;
    tick();
    set_int(1'b1, 3'd5, 5'd3, 30'd70, 32'd300);
    tick();
    chk("eq_prio_noredirect", {31'd0, redirect}, 0);
    chk("eq_prio_level", {29'd0, level}, 2);
    int_prio = 3'd2;
    tick();
    chk("low_prio_noredirect", {31'd0, redirect}, 0);
    int_req = 1'b0;

    // Returns
    ret_req = 1'b1;
    tick();
    chk("ret1_redirect", {31'd0, redirect}, 1);
    chk("ret1_pc", redirect_pc, 144);
    chk("ret1_ack", {31'd0, int_ack}, 0);
    chk("ret1_level", {29'd0, level}, 1);
    chk("ret1_thresh", {29'd0, thresh}, 3);
    tick();
    chk("exit_busy_redirect", {31'd0, redirect}, 0);
    tick();
    chk("ret2_pc", redirect_pc, 28);
    chk("ret2_level", {29'd0, level}, 0);
    chk("ret2_thresh", {29'd0, thresh}, 0);
    ret_req = 1'b0;
    tick();

    // Tail-chain from level 1 with saved threshold 0
    set_int(1'b1, 3'd1, 5'd1, 30'd35, 32'd28);
    tick();
    chk("tc_take_level", {29'd0, level}, 1);
    int_req = 1'b0;
    tick();
    set_int(1'b1, 3'd2, 5'd3, 30'd60, 32'd500);
    ret_req = 1'b1;
    tick();
    chk("tc_pc", redirect_pc, 240);
    chk("tc_ack", {31'd0, int_ack}, 1);
    chk("tc_vec", {27'd0, ack_vec}, 3);
    chk("tc_level", {29'd0, level}, 1);
    chk("tc_thresh", {29'd0, thresh}, 2);
    int_req = 1'b0;
    tick();
    tick();
    chk("tc_ret_pc", redirect_pc, 28);
    chk("tc_ret_level", {29'd0, level}, 0);
    ret_req = 1'b0;
    tick();

    // Fill the stack, then overflow
    for (int p = 1; p <= 4; p++) begin
      set_int(1'b1, 3'(p), 5'(p), 30'(p * 16), 32'(p * 64));
      tick();
      int_req = 1'b0;
      tick();
    end
    chk("full_level", {29'd0, level}, 4);
    chk("full_thresh", {29'd0, thresh}, 4);
    set_int(1'b1, 3'd6, 5'd9, 30'd99, 32'd1000);
    tick();
    chk("ovf_redirect", {31'd0, redirect}, 0);
    chk("ovf_ack", {31'd0, int_ack}, 0);
    chk("ovf_err", {31'd0, ovf_err}, 1);
    chk("ovf_level", {29'd0, level}, 4);
    int_req = 1'b0;
    tick();
    chk("ovf_sticky", {31'd0, ovf_err}, 1);
    ret_req = 1'b1;
    tick();
    chk("pop4_pc", redirect_pc, 256);
    chk("pop4_thresh", {29'd0, thresh}, 3);
    ret_req = 1'b0;

    // Reset, then underflow
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_ovf", {31'd0, ovf_err}, 0);
    ret_req = 1'b1;
    tick();
    chk("unf_err", {31'd0, unf_err}, 1);
    chk("unf_redirect", {31'd0, redirect}, 0);
    chk("unf_level", {29'd0, level}, 0);
    ret_req = 1'b0;
    tick();
    chk("unf_sticky", {31'd0, unf_err}, 1);

    // Reset landing during an ENTRY cycle
    set_int(1'b1, 3'd2, 5'd7, 30'd80, 32'd400);
    tick();
    chk("pre_rst_ack", {31'd0, int_ack}, 1);
    int_req = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_entry_redirect", {31'd0, redirect}, 0);
    chk("rst_entry_ack", {31'd0, int_ack}, 0);
    chk("rst_entry_pc", redirect_pc, 0);
    chk("rst_entry_vec", {27'd0, ack_vec}, 0);
    chk("rst_entry_level", {29'd0, level}, 0);
    chk("rst_entry_thresh", {29'd0, thresh}, 0);
    chk("rst_entry_unf", {31'd0, unf_err}, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_redirect", {31'd0, redirect}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
